// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared types and stage index constants for the stage sequencer
package stage_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    HALT
  } seq_state_t;

  localparam int STAGE_IF = 0;
  localparam int IF_ID    = 1;
  localparam int ID       = 2;
  localparam int ID_EX    = 3;
  localparam int EX_MEM   = 4;
  localparam int MEM      = 5;
  localparam int MEM_WB   = 6;
  localparam int WB       = 7;
  localparam int WB_IF    = 8;

  localparam int DEFAULT_N_STAGES = 9;

endpackage

// File: rtl/stage_next_sel.sv
// rtl/stage_next_sel.sv - picks the next unskipped stage after cur, flagging wrap to stage 0
module stage_next_sel #(
  parameter int N_STAGES = 9
) (
  input  logic [$clog2(N_STAGES)-1:0] cur,
  input  logic [N_STAGES-1:0]         skip_mask,
  output logic [$clog2(N_STAGES)-1:0] next,
  output logic                        wrap
);

  localparam int SW = $clog2(N_STAGES);

  // Stage 0 is never skippable, so its mask bit is deliberately left unread.
  logic unused_skip0;
  assign unused_skip0 = skip_mask[0];

  // Descending scan: the lowest qualifying index is the last one written.
  always_comb begin
    next = '0;
    wrap = 1'b1;
    for (int j = N_STAGES - 1; j >= 1; j--) begin
      if ((SW'(j) > cur) && !skip_mask[j]) begin
        next = SW'(j);
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage ring with skip, stall, halt/resume and retire count
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int N_STAGES = DEFAULT_N_STAGES,
  parameter int CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [N_STAGES-1:0]         skip_mask,
  input  logic                        halt_req,
  input  logic                        resume,
  output logic [N_STAGES-1:0]         stage_en,
  output logic [$clog2(N_STAGES)-1:0] stage,
  output logic                        stage_reset_n,
  output logic                        instr_done,
  output logic                        halted,
  output logic [CNT_W-1:0]            instr_count
);

  localparam int SW = $clog2(N_STAGES);

  seq_state_t    state, state_next;
  logic [SW-1:0] stage_next;
  logic [SW-1:0] sel_next;
  logic          sel_wrap;
  logic          count_inc;

  stage_next_sel #(
    .N_STAGES(N_STAGES)
  ) u_next_sel (
    .cur       (stage),
    .skip_mask (skip_mask),
    .next      (sel_next),
    .wrap      (sel_wrap)
  );

  always_comb begin
    state_next    = state;
    stage_next    = stage;
    stage_en      = '0;
    stage_reset_n = 1'b1;
    instr_done    = 1'b0;
    halted        = 1'b0;
    count_inc     = 1'b0;
    case (state)
      INIT: begin
        stage_reset_n = 1'b0;
        state_next    = RUN;
        stage_next    = '0;
      end
      RUN: begin
        stage_en = {{(N_STAGES-1){1'b0}}, ~stall} << stage;
        if (!stall) begin
          stage_next = sel_next;
          // The halt decision is only taken at the instruction boundary.
          if (sel_wrap) begin
            instr_done = 1'b1;
            count_inc  = 1'b1;
            stage_next = '0;
            if (halt_req) state_next = HALT;
          end
        end
      end
      HALT: begin
        halted     = 1'b1;
        stage_next = '0;
        if (resume) state_next = RUN;
      end
      default: begin
        state_next = INIT;
        stage_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      stage       <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      stage <= stage_next;
      if (count_inc) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [8:0]  skip_mask;
  logic        halt_req;
  logic        resume;
  logic [8:0]  stage_en;
  logic [3:0]  stage;
  logic        stage_reset_n;
  logic        instr_done;
  logic        halted;
  logic [31:0] instr_count;

  logic        stall_b;
  logic [8:0]  skip_b;
  logic        halt_b;
  logic        resume_b;
  logic [8:0]  stage_en_b;
  logic [3:0]  stage_b;
  logic        stage_reset_n_b;
  logic        instr_done_b;
  logic        halted_b;
  logic [3:0]  instr_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage_sequencer u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .skip_mask     (skip_mask),
    .halt_req      (halt_req),
    .resume        (resume),
    .stage_en      (stage_en),
    .stage         (stage),
    .stage_reset_n (stage_reset_n),
    .instr_done    (instr_done),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  stage_sequencer #(.N_STAGES(9), .CNT_W(4)) u_small (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall_b),
    .skip_mask     (skip_b),
    .halt_req      (halt_b),
    .resume        (resume_b),
    .stage_en      (stage_en_b),
    .stage         (stage_b),
    .stage_reset_n (stage_reset_n_b),
    .instr_done    (instr_done_b),
    .halted        (halted_b),
    .instr_count   (instr_count_b)
  );

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (stage_en !== 9'd0) begin n_fail++; $display("FAIL reset_stage_en got=%b exp=%b", stage_en, 9'd0); end
    n_checks++; if (stage !== 4'd0) begin n_fail++; $display("FAIL reset_stage got=%0d exp=0", stage); end
    n_checks++; if (stage_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_stage_reset_n got=%b exp=0", stage_reset_n); end
    n_checks++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_instr_done got=%b exp=0", instr_done); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    reset = 1'b0;
  endtask

  task automatic test_plain_ring();
    int es, ec;
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      @(negedge clk);
      es = (e - 1) % 9;
      ec = (e - 1) / 9;
      n_checks++; if (stage !== 4'(es)) begin n_fail++; $display("FAIL plain_stage e=%0d got=%0d exp=%0d", e, stage, es); end
      n_checks++; if (stage_en !== (9'd1 << es)) begin n_fail++; $display("FAIL plain_stage_en e=%0d got=%b exp=%b", e, stage_en, 9'd1 << es); end
      n_checks++; if (instr_done !== (es == 8)) begin n_fail++; $display("FAIL plain_instr_done e=%0d got=%b exp=%b", e, instr_done, es == 8); end
      n_checks++; if (instr_count !== 32'(ec)) begin n_fail++; $display("FAIL plain_count e=%0d got=%0d exp=%0d", e, instr_count, ec); end
    end
  endtask

  task automatic test_skip_mem();
    int seq [8] = '{0, 1, 2, 3, 4, 6, 7, 8};
    int es, ec;
    skip_mask = 9'b000100000;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      es = seq[(e - 1) % 8];
      ec = (e - 1) / 8;
      n_checks++; if (stage !== 4'(es)) begin n_fail++; $display("FAIL skip_stage e=%0d got=%0d exp=%0d", e, stage, es); end
      n_checks++; if (stage_en[5] !== 1'b0) begin n_fail++; $display("FAIL skip_en5 e=%0d got=%b exp=0", e, stage_en[5]); end
      n_checks++; if (instr_done !== (es == 8)) begin n_fail++; $display("FAIL skip_instr_done e=%0d got=%b exp=%b", e, instr_done, es == 8); end
      n_checks++; if (instr_count !== 32'(ec)) begin n_fail++; $display("FAIL skip_count e=%0d got=%0d exp=%0d", e, instr_count, ec); end
    end
    skip_mask = 9'd0;
  endtask

  task automatic test_stall();
    do_reset();
    repeat (6) @(negedge clk);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++; if (stage !== 4'd5) begin n_fail++; $display("FAIL stall_hold_stage i=%0d got=%0d exp=5", i, stage); end
      n_checks++; if (stage_en !== 9'd0) begin n_fail++; $display("FAIL stall_hold_en i=%0d got=%b exp=0", i, stage_en); end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    n_checks++; if (stage !== 4'd5) begin n_fail++; $display("FAIL stall_release_stage got=%0d exp=5", stage); end
    n_checks++; if (stage_en !== 9'b000100000) begin n_fail++; $display("FAIL stall_release_en got=%b exp=000100000", stage_en); end
    repeat (3) @(negedge clk);
    n_checks++; if (stage !== 4'd8 || instr_done !== 1'b1) begin n_fail++; $display("FAIL stall_wrap_cycle stage=%0d done=%b exp stage=8 done=1", stage, instr_done); end
    n_checks++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL stall_count_before got=%0d exp=0", instr_count); end
    @(negedge clk);
    n_checks++; if (stage !== 4'd0 || instr_count !== 32'd1) begin n_fail++; $display("FAIL stall_12cyc stage=%0d count=%0d exp stage=0 count=1", stage, instr_count); end
    repeat (8) @(negedge clk);
    stall = 1'b1;
    #1;
    n_checks++; if (stage !== 4'd8 || instr_done !== 1'b0) begin n_fail++; $display("FAIL stall_wb_a stage=%0d done=%b exp stage=8 done=0", stage, instr_done); end
    @(negedge clk);
    n_checks++; if (stage !== 4'd8 || instr_done !== 1'b0 || instr_count !== 32'd1) begin n_fail++; $display("FAIL stall_wb_b stage=%0d done=%b count=%0d exp 8/0/1", stage, instr_done, instr_count); end
    stall = 1'b0;
    #1;
    n_checks++; if (instr_done !== 1'b1) begin n_fail++; $display("FAIL stall_wb_done got=%b exp=1", instr_done); end
    @(negedge clk);
    n_checks++; if (stage !== 4'd0 || instr_count !== 32'd2) begin n_fail++; $display("FAIL stall_wb_after stage=%0d count=%0d exp 0/2", stage, instr_count); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (stage !== 4'd3) begin n_fail++; $display("FAIL halt_at3 got=%0d exp=3", stage); end
    halt_req = 1'b1;
    for (int s = 4; s <= 8; s++) begin
      @(negedge clk);
      n_checks++; if (stage !== 4'(s) || halted !== 1'b0) begin n_fail++; $display("FAIL halt_drain stage=%0d halted=%b exp stage=%0d halted=0", stage, halted, s); end
    end
    n_checks++; if (instr_done !== 1'b1) begin n_fail++; $display("FAIL halt_instr_done got=%b exp=1", instr_done); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) stall = 1'b1;
      #1;
      n_checks++; if (halted !== 1'b1 || stage_en !== 9'd0 || stage !== 4'd0) begin n_fail++; $display("FAIL halt_parked i=%0d halted=%b en=%b stage=%0d exp 1/0/0", i, halted, stage_en, stage); end
    end
    stall = 1'b0;
    n_checks++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL halt_count got=%0d exp=1", instr_count); end
    halt_req = 1'b0;
    resume   = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || stage !== 4'd0 || stage_en !== 9'd1) begin n_fail++; $display("FAIL halt_resume halted=%b stage=%0d en=%b exp 0/0/000000001", halted, stage, stage_en); end
    halt_req = 1'b1;
    repeat (9) @(negedge clk);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_second got=%b exp=1", halted); end
    resume = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    resume   = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || stage_en !== 9'd1) begin n_fail++; $display("FAIL halt_both_resume halted=%b en=%b exp 0/000000001", halted, stage_en); end
  endtask

  task automatic test_all_skip();
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      n_checks++; if (stage_b !== 4'd0 || instr_done_b !== 1'b1) begin n_fail++; $display("FAIL allskip_cycle e=%0d stage=%0d done=%b exp 0/1", e, stage_b, instr_done_b); end
      n_checks++; if (instr_count_b !== 4'(e - 1)) begin n_fail++; $display("FAIL allskip_count e=%0d got=%0d exp=%0d", e, instr_count_b, 4'(e - 1)); end
    end
    stall_b = 1'b1;
    #1;
    n_checks++; if (instr_done_b !== 1'b0 || stage_en_b !== 9'd0) begin n_fail++; $display("FAIL allskip_stall done=%b en=%b exp 0/0", instr_done_b, stage_en_b); end
    stall_b = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (14) @(negedge clk);
    n_checks++; if (stage !== 4'd4 || instr_count !== 32'd1) begin n_fail++; $display("FAIL areset_pre stage=%0d count=%0d exp 4/1", stage, instr_count); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (stage !== 4'd0 || stage_en !== 9'd0) begin n_fail++; $display("FAIL areset_stage stage=%0d en=%b exp 0/0", stage, stage_en); end
    n_checks++; if (stage_reset_n !== 1'b0 || instr_count !== 32'd0) begin n_fail++; $display("FAIL areset_clr srn=%b count=%0d exp 0/0", stage_reset_n, instr_count); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (stage_reset_n !== 1'b0) begin n_fail++; $display("FAIL areset_init srn=%b exp=0", stage_reset_n); end
    @(negedge clk);
    n_checks++; if (stage_reset_n !== 1'b1 || stage_en !== 9'd1 || instr_count !== 32'd0) begin n_fail++; $display("FAIL areset_restart srn=%b en=%b count=%0d exp 1/000000001/0", stage_reset_n, stage_en, instr_count); end
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    skip_mask = 9'd0;
    halt_req  = 1'b0;
    resume    = 1'b0;
    stall_b   = 1'b0;
    skip_b    = 9'h1FF;
    halt_b    = 1'b0;
    resume_b  = 1'b0;
    test_reset();
    test_plain_ring();
    test_skip_mem();
    test_stall();
    test_halt();
    test_all_skip();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multi-cycle stage sequencer for the non-pipelined core. It walks a configurable number of stages in a ring and emits a one-hot per-stage write-enable vector for the PC, inter-stage registers, RAM and register file. Beyond a fixed ring, it supports:
- per-instruction stage skipping (e.g. bypassing MEM for ALU ops);
- stalls (multi-cycle memory or IO);
- a clean halt/resume at instruction boundaries;
- a retired-instruction counter.

## Interface
- `N_STAGES`, default 9: number of stages in the ring. Index 0 is always IF.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hold the current stage; suppresses its enable.
- `skip_mask` in `N_STAGES`: bit j=1 bypasses stage j on the next advance. Bit 0 is ignored.
- `halt_req` in 1: level; park in HALT at the next instruction boundary.
- `resume` in 1: level; leave HALT.
- `stage_en` out `N_STAGES`: one-hot enable for the current stage, gated by `!stall`.
- `stage` out `$clog2(N_STAGES)`: current stage index.
- `stage_reset_n` out 1: low only in INIT; drives the datapath stage-register clear.
- `instr_done` out 1: single-cycle pulse in the last active stage of an instruction.
- `halted` out 1: high in HALT.
- `instr_count` out `CNT_W`: retired-instruction count.

## Operation
- FSM states: INIT, RUN, HALT. Registers: `state`, `stage`, `instr_count`.
- INIT:
  - `stage=0`, `stage_reset_n=0`.
  - Moves to RUN with `stage=0` unconditionally on the first clock edge.
- RUN, stage k:
  - `stage_en[k] = !stall`; all other bits 0.
  - Advances only when `stall=0`.
  - Next index = first j in k+1..N_STAGES-1 with `skip_mask[j]=0`; if none, 0 (wrap).
  - `skip_mask` is sampled in the advancing cycle only.
- Wrap (next index is 0):
  - `instr_done=1` in that cycle (combinational, and only when `stall=0`).
  - `instr_count` increments modulo 2^CNT_W.
  - If `halt_req=1` in that cycle, go to HALT; otherwise go to RUN with `stage=0`.
- HALT:
  - `stage_en=0`, `halted=1`, `stage` holds 0.
  - `resume=1` returns to RUN with `stage=0` on the next edge.
  - `halt_req` and `resume` both high: `resume` wins.
- `halt_req` asserted mid-instruction does not truncate the instruction: remaining stages run, including stalls.
- `stall` in the wrap cycle defers both `instr_done` and the halt decision.
- All `skip_mask` bits set: only stage 0 runs; `instr_done` fires every unstalled cycle.
- `stall` in INIT or HALT is ignored.

## Timing
- `reset` asserted: immediately (asynchronously) `state=INIT`, `stage=0`, `stage_en=0`, `stage_reset_n=0`, `instr_done=0`, `halted=0`, `instr_count=0`.
- After `reset` deasserts, first edge: RUN, stage 0. `stage_en[0]` is high in the following cycle.
- Each unstalled stage lasts exactly 1 cycle. Each stall cycle adds 1 cycle.
- Instruction latency = (number of unskipped stages) + (stall cycles).
- `stage_en` and `instr_done` are combinational from registered state plus `stall`/`skip_mask`. Consumers sample them on the same edge as the advance.
- `instr_count` updates on the edge that ends the wrap cycle.
- HALT→RUN latency: 1 edge after `resume`.
- Reset mid-instruction aborts it: the count is not incremented, and `stage_reset_n` clears datapath registers.

## Structure
- Package `stage_pkg`:
  - FSM enum `seq_state_t` {INIT, RUN, HALT}.
  - Default stage index constants `STAGE_IF=0`, `IF_ID=1`, `ID=2`, `ID_EX=3`, `EX_MEM=4`, `MEM=5`, `MEM_WB=6`, `WB=7`, `WB_IF=8`.
  - `DEFAULT_N_STAGES=9`.
- Sub-module `stage_next_sel`: combinational wrap-around priority finder.
  - Inputs: `cur`, `skip_mask`.
  - Outputs: `next`, `wrap`.
  - Parametrised by `N_STAGES`.

## Test plan
- Default params, no stall/skip, release reset: stages 0..8 one cycle each. `instr_done` high during stage 8. `instr_count=1` after 10 edges from deassert; `instr_count=3` after 28.
- `skip_mask=9'b000100000` (MEM skipped): `stage` sequence 0,1,2,3,4,6,7,8,0. `stage_en[5]` never high. 8 cycles per instruction.
- `stall` high for 3 cycles while in stage 5:
  - `stage=5` for 4 cycles; `stage_en[5]` high only in the 4th.
  - The instruction takes 12 cycles.
  - `stall` during stage 8 delays `instr_done` by the same number of cycles.
- `halt_req` asserted in stage 3:
  - Stages 4..8 complete and `instr_done` pulses.
  - Then `halted=1` and `stage_en=0` for 20 cycles.
  - `resume` pulse → stage 0 on the next edge. `halt_req`+`resume` together in HALT → resumes.
- `skip_mask` all ones, `CNT_W=4`: `stage` stays 0, `instr_done` every cycle, `instr_count` wraps 15→0 after 16 cycles.
- Assert `reset` asynchronously mid-stage 4: outputs take reset values before the next edge. `instr_count=0`. Restart follows the INIT→stage 0 sequence.
